// File: rtl/seq_divider16.sv
// Restoring shift-subtract divider producing one quotient bit per clock.
// Signed mode divides magnitudes, then restores signs (truncating division).
module seq_divider16 #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             ovflow
);

    // state  | meaning
    // IDLE   | waiting for start; result outputs hold the last operation
    // RUN    | one restoring iteration per cycle, WIDTH cycles in total
    // FIX    | sign correction, result outputs written
    // DONE   | one cycle; done pulses on the following cycle
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic             busy_q;
    logic             done_q;
    logic             dz_q;
    logic             ov_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic             dvd_neg_d;
    logic             dvs_neg_d;
    logic [WIDTH-1:0] dvd_mag_d;
    logic [WIDTH-1:0] dvs_mag_d;
    logic             ovf_case_d;
    logic [WIDTH:0]   shift_d;
    logic [WIDTH:0]   trial_d;
    logic             borrow_d;
    logic [WIDTH-1:0] quo_fix_d;
    logic [WIDTH-1:0] rem_fix_d;

    always_comb begin
        dvd_neg_d  = sign & dividend[WIDTH-1];
        dvs_neg_d  = sign & divisor[WIDTH-1];
        dvd_mag_d  = dvd_neg_d ? -dividend : dividend;
        dvs_mag_d  = dvs_neg_d ? -divisor : divisor;
        ovf_case_d = sign && (dividend == MIN_NEG) && (divisor == '1);
        shift_d    = {rem_q, quo_q[WIDTH-1]};
        // Partial remainder stays below the divisor, so shift_d < 2*divisor:
        // a non-negative difference fits in WIDTH bits and bit WIDTH is the borrow.
        trial_d    = shift_d - {1'b0, dvs_q};
        borrow_d   = trial_d[WIDTH];
        quo_fix_d  = q_neg_q ? -quo_q : quo_q;
        rem_fix_d  = r_neg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        q_neg_q <= dvd_neg_d ^ dvs_neg_d;
                        r_neg_q <= dvd_neg_d;
                        quo_q   <= dvd_mag_d;
                        dvs_q   <= dvs_mag_d;
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        dz_q    <= 1'b0;
                        ov_q    <= 1'b0;
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dz_q        <= 1'b1;
                            state_q     <= S_DONE;
                        end else if (ovf_case_d) begin
                            quotient_q  <= MIN_NEG;
                            remainder_q <= '0;
                            ov_q        <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= borrow_d ? shift_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ~borrow_d};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient_q  <= quo_fix_d;
                    remainder_q <= rem_fix_d;
                    busy_q      <= 1'b0;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dz_q;
    assign ovflow      = ov_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed cases, randomized ops against
// an arithmetic reference model, start-ignore, mid-run reset and back-to-back.
module tb_seq_divider16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        sign;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        ovflow;

    int checks = 0;
    int errors = 0;

    seq_divider16 #(.WIDTH(16), .CNT_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .sign(sign),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .ovflow(ovflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed vectors: a, b, sign -> quotient, remainder, dz, ovf, latency
    localparam logic [15:0] DA   [7] = '{16'hF123, 16'hF123, 16'h7123, 16'h1234, 16'h1234, 16'h8000, 16'h8000};
    localparam logic [15:0] DB   [7] = '{16'h1345, 16'h1345, 16'hF345, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    localparam logic        DS   [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [15:0] DQ   [7] = '{16'h000C, 16'h0000, 16'hFFF8, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
    localparam logic [15:0] DR   [7] = '{16'h09E7, 16'hF123, 16'h0B4B, 16'h1234, 16'h1234, 16'h0000, 16'h8000};
    localparam logic        DDZ  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam logic        DOV  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam int          DLAT [7] = '{18, 18, 18, 1, 1, 1, 18};

    // Reference model: plain integer division, truncating toward zero when signed.
    function automatic void ref_div(input logic [15:0] a, input logic [15:0] b, input logic s,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic dz, output logic ov, output int lat);
        int ia;
        int ib;
        int iq;
        int ir;
        dz = (b == 16'h0000);
        ov = s && (a == 16'h8000) && (b == 16'hFFFF);
        if (dz) begin
            q = 16'hFFFF;
            r = a;
            lat = 1;
        end else if (ov) begin
            q = 16'h8000;
            r = 16'h0000;
            lat = 1;
        end else begin
            ia = s ? int'($signed(a)) : int'(a);
            ib = s ? int'($signed(b)) : int'(b);
            iq = ia / ib;
            ir = ia % ib;
            q = iq[15:0];
            r = ir[15:0];
            lat = 18;
        end
    endfunction

    // Called #1 after an edge with the DUT idle; returns #1 after the done edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output int lat, output bit busy_seen);
        dividend = a;
        divisor  = b;
        sign     = s;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        busy_seen = busy;
        lat       = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        dividend = 16'h0;
        divisor = 16'h0;
        sign = 1'b0;
        #12;
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        if (quotient !== 16'h0) begin errors++; $display("FAIL reset_quotient: got %h expected 0000", quotient); end
        if (remainder !== 16'h0) begin errors++; $display("FAIL reset_remainder: got %h expected 0000", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
        if (ovflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovflow); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        int lat;
        bit bs;
        for (int k = 0; k < 7; k++) begin
            issue(DA[k], DB[k], DS[k], lat, bs);
            checks += 6;
            if (lat !== DLAT[k]) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", k, lat, DLAT[k]); end
            if (quotient !== DQ[k]) begin errors++; $display("FAIL dir%0d_quotient: got %h expected %h", k, quotient, DQ[k]); end
            if (remainder !== DR[k]) begin errors++; $display("FAIL dir%0d_remainder: got %h expected %h", k, remainder, DR[k]); end
            if (div_by_zero !== DDZ[k]) begin errors++; $display("FAIL dir%0d_dz: got %b expected %b", k, div_by_zero, DDZ[k]); end
            if (ovflow !== DOV[k]) begin errors++; $display("FAIL dir%0d_ovf: got %b expected %b", k, ovflow, DOV[k]); end
            if (bs !== (DLAT[k] == 18)) begin errors++; $display("FAIL dir%0d_busy_seen: got %b expected %b", k, bs, DLAT[k] == 18); end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_single: got %b expected 0", k, done); end
        end
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        logic        eov;
        int          elat;
        int          lat;
        bit          bs;
        for (int n = 0; n < 60; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: b = 16'h0000;
                1: b = 16'($urandom_range(1, 15));
                2: b = 16'hFFFF;
                3: a = 16'h8000;
                4: begin a = 16'h8000; b = 16'hFFFF; end
                default: ;
            endcase
            ref_div(a, b, s, eq, er, edz, eov, elat);
            issue(a, b, s, lat, bs);
            checks += 5;
            if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, elat); end
            if (quotient !== eq) begin errors++; $display("FAIL rnd%0d_quotient %h/%h s=%b: got %h expected %h", n, a, b, s, quotient, eq); end
            if (remainder !== er) begin errors++; $display("FAIL rnd%0d_remainder %h/%h s=%b: got %h expected %h", n, a, b, s, remainder, er); end
            if (div_by_zero !== edz) begin errors++; $display("FAIL rnd%0d_dz: got %b expected %b", n, div_by_zero, edz); end
            if (ovflow !== eov) begin errors++; $display("FAIL rnd%0d_ovf: got %b expected %b", n, ovflow, eov); end
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        logic        eov;
        int          elat;
        int          first_lat;
        int          ndone;
        int          nbusy;
        ref_div(16'hF123, 16'h1345, 1'b0, eq, er, edz, eov, elat);
        dividend = 16'hF123;
        divisor  = 16'h1345;
        sign     = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_lat = -1;
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 5) begin
                dividend = 16'h1234;
                divisor  = 16'h0000;
                sign     = 1'b1;
                start    = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (first_lat < 0) first_lat = i;
            end
        end
        checks += 5;
        if (ndone !== 1) begin errors++; $display("FAIL run_start_done_count: got %0d expected 1", ndone); end
        if (first_lat !== elat) begin errors++; $display("FAIL run_start_latency: got %0d expected %0d", first_lat, elat); end
        if (quotient !== eq) begin errors++; $display("FAIL run_start_quotient: got %h expected %h", quotient, eq); end
        if (remainder !== er) begin errors++; $display("FAIL run_start_remainder: got %h expected %h", remainder, er); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL run_start_dz: got %b expected 0", div_by_zero); end

        // Start held through the DONE state of a divide-by-zero must not re-trigger.
        dividend = 16'h1234;
        divisor  = 16'h0000;
        sign     = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = done ? 1 : 0;
        nbusy = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (busy) nbusy++;
        end
        checks += 3;
        if (ndone !== 1) begin errors++; $display("FAIL done_start_done_count: got %0d expected 1", ndone); end
        if (nbusy !== 0) begin errors++; $display("FAIL done_start_busy_cycles: got %0d expected 0", nbusy); end
        if (div_by_zero !== 1'b1) begin errors++; $display("FAIL done_start_dz: got %b expected 1", div_by_zero); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        logic        eov;
        int          elat;
        int          lat;
        bit          bs;
        dividend = 16'h7123;
        divisor  = 16'hF345;
        sign     = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks += 6;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done); end
        if (quotient !== 16'h0) begin errors++; $display("FAIL midrst_quotient: got %h expected 0000", quotient); end
        if (remainder !== 16'h0) begin errors++; $display("FAIL midrst_remainder: got %h expected 0000", remainder); end
        if (div_by_zero !== 1'b0) begin errors++; $display("FAIL midrst_dz: got %b expected 0", div_by_zero); end
        if (ovflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b expected 0", ovflow); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b expected 0", done); end
        ref_div(16'hF123, 16'h1345, 1'b1, eq, er, edz, eov, elat);
        issue(16'hF123, 16'h1345, 1'b1, lat, bs);
        checks += 3;
        if (lat !== elat) begin errors++; $display("FAIL after_rst_latency: got %0d expected %0d", lat, elat); end
        if (quotient !== eq) begin errors++; $display("FAIL after_rst_quotient: got %h expected %h", quotient, eq); end
        if (remainder !== er) begin errors++; $display("FAIL after_rst_remainder: got %h expected %h", remainder, er); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] q1;
        logic [15:0] r1;
        logic [15:0] q2;
        logic [15:0] r2;
        logic        edz;
        logic        eov;
        int          elat;
        int          lat;
        bit          bs;
        logic [15:0] a2;
        logic [15:0] b2;
        ref_div(16'h9999, 16'h0007, 1'b0, q1, r1, edz, eov, elat);
        issue(16'h9999, 16'h0007, 1'b0, lat, bs);
        a2 = 16'($urandom);
        b2 = 16'($urandom_range(2, 16'h7FFF));
        ref_div(a2, b2, 1'b1, q2, r2, edz, eov, elat);
        // Start in the same cycle done is high.
        dividend = a2;
        divisor  = b2;
        sign     = 1'b1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                checks += 2;
                if (quotient !== q1) begin errors++; $display("FAIL b2b_hold_quotient: got %h expected %h", quotient, q1); end
                if (remainder !== r1) begin errors++; $display("FAIL b2b_hold_remainder: got %h expected %h", remainder, r1); end
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        checks += 3;
        if (lat !== elat) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", lat, elat); end
        if (quotient !== q2) begin errors++; $display("FAIL b2b_quotient %h/%h: got %h expected %h", a2, b2, quotient, q2); end
        if (remainder !== r2) begin errors++; $display("FAIL b2b_remainder %h/%h: got %h expected %h", a2, b2, remainder, r2); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
